// File: rtl/uart_tx_if.sv
// Parallel-side handshake and serial line of the UART transmitter.
// The requester (system controller or TX FIFO) holds the master modport; uart_tx holds the slave.
interface uart_tx_if;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [5:0] Prescale;
  logic       TX_OUT;
  logic       busy;

  modport master (
    output P_DATA,
    output DATA_VALID,
    output PAR_EN,
    output PAR_TYP,
    output Prescale,
    input  TX_OUT,
    input  busy
  );

  modport slave (
    input  P_DATA,
    input  DATA_VALID,
    input  PAR_EN,
    input  PAR_TYP,
    input  Prescale,
    output TX_OUT,
    output busy
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional even/odd parity, 1 stop bit.
// Each bit lasts Prescale clk cycles (0 behaves as 1); TX_OUT and busy are registered.
//
// state  | meaning
// IDLE   | line high, busy low, waiting for DATA_VALID
// START  | start bit (line low)
// DATA   | data bit bit_cnt of the latched word
// PARITY | parity of the latched word, inverted for odd parity
// STOP   | stop bit (line high)
module uart_tx (
  input  logic     CLK,
  input  logic     RST,
  uart_tx_if.slave tx
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [5:0] edge_cnt_q, edge_cnt_d;
  logic [7:0] data_q, data_d;
  logic       par_en_q, par_en_d;
  logic       par_typ_q, par_typ_d;
  logic [5:0] prescale_q, prescale_d;
  logic       tx_q, tx_d;
  logic       busy_q, busy_d;

  logic [5:0] last_edge;
  logic       bit_end;
  logic       parity_bit;

  // A latched prescale of 0 ends every bit on its first cycle, same as 1.
  assign last_edge  = (prescale_q == 6'd0) ? 6'd0 : (prescale_q - 6'd1);
  assign bit_end    = (edge_cnt_q == last_edge);
  assign parity_bit = (^data_q) ^ par_typ_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      edge_cnt_q <= 6'd0;
      data_q     <= 8'd0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      prescale_q <= 6'd0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      data_q     <= data_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      prescale_q <= prescale_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    edge_cnt_d = edge_cnt_q;
    data_d     = data_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    prescale_d = prescale_q;

    if (state_q != IDLE) begin
      edge_cnt_d = bit_end ? 6'd0 : (edge_cnt_q + 6'd1);
    end

    case (state_q)
      IDLE: begin
        edge_cnt_d = 6'd0;
        bit_cnt_d  = 3'd0;
        if (tx.DATA_VALID) begin
          data_d     = tx.P_DATA;
          par_en_d   = tx.PAR_EN;
          par_typ_d  = tx.PAR_TYP;
          prescale_d = tx.Prescale;
          state_d    = START;
        end
      end
      START: begin
        if (bit_end) state_d = DATA;
      end
      DATA: begin
        if (bit_end) begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
      STOP: begin
        if (bit_end) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the start bit and busy appear on the accepting edge.
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != IDLE);
    case (state_d)
      IDLE:    tx_d = 1'b1;
      START:   tx_d = 1'b0;
      DATA:    tx_d = data_d[bit_cnt_d];
      PARITY:  tx_d = parity_bit;
      STOP:    tx_d = 1'b1;
      default: tx_d = 1'b1;
    endcase
  end

  assign tx.TX_OUT = tx_q;
  assign tx.busy   = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a vector table of frames plus hand-written corner sequences,
// with a line monitor that pops expected frames from a scoreboard queue.
module tb_uart_tx;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       pt;
    logic [5:0] pre;
    logic       exp_par;
    int         exp_len;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  uart_tx_if tx_if ();

  uart_tx dut (
    .CLK (clk),
    .RST (rst),
    .tx  (tx_if.slave)
  );

  int   checks   = 0;
  int   failures = 0;
  vec_t sb_q[$];
  logic mon_en   = 1'b0;
  logic in_frame = 1'b0;
  int   cyc      = 0;
  int   last_end = 0;
  int   last_gap = -1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [7:0] d, input logic pe, input logic pt,
                              input logic [5:0] pre, input logic par, input int len);
    vec_t v;
    v.data = d; v.pe = pe; v.pt = pt; v.pre = pre; v.exp_par = par; v.exp_len = len;
    return v;
  endfunction

  // Expected line level at cycle i of a frame.
  function automatic logic exp_line(input vec_t v, input int i);
    int p;
    int b;
    p = (v.pre == 6'd0) ? 1 : int'(v.pre);
    b = i / p;
    if (b == 0) return 1'b0;
    if (b <= 8) return v.data[b-1];
    if (b == 9 && v.pe) return v.exp_par;
    return 1'b1;
  endfunction

  // Line monitor: samples 1 time unit after each rising edge.
  initial begin
    vec_t cur;
    int   idx;
    int   bad_idx;
    logic skip;
    cur = mk(8'h00, 1'b0, 1'b0, 6'd1, 1'b0, 10);
    idx = 0; bad_idx = -1; skip = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!mon_en || rst) begin
        in_frame = 1'b0;
        skip     = 1'b0;
        continue;
      end
      if (skip) begin
        if (tx_if.busy === 1'b0) skip = 1'b0;
        continue;
      end
      if (!in_frame && tx_if.busy === 1'b1) begin
        check("frame_expected", sb_q.size() > 0, 1);
        if (sb_q.size() == 0) begin
          skip = 1'b1;
          continue;
        end
        cur      = sb_q.pop_front();
        in_frame = 1'b1;
        idx      = 0;
        bad_idx  = -1;
        last_gap = cyc - last_end;
      end
      if (in_frame) begin
        if (tx_if.busy === 1'b1) begin
          if (tx_if.TX_OUT !== exp_line(cur, idx) && bad_idx < 0) bad_idx = idx;
          idx++;
        end else begin
          check($sformatf("frame_wave_%02h_first_bad_cycle", cur.data), bad_idx, -1);
          check($sformatf("frame_len_%02h", cur.data), idx, cur.exp_len);
          if (tx_if.TX_OUT !== 1'b1) check("line_high_after_stop", tx_if.TX_OUT, 1);
          in_frame = 1'b0;
          last_end = cyc;
        end
      end
    end
  end

  task automatic wait_idle();
    int n = 0;
    while (tx_if.busy !== 1'b0 && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 3000) check("wait_idle_timeout", n, 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((sb_q.size() != 0 || in_frame) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 3000) check("wait_done_timeout", n, 0);
  endtask

  task automatic send(input vec_t v, input logic hold);
    wait_idle();
    tx_if.P_DATA     = v.data;
    tx_if.PAR_EN     = v.pe;
    tx_if.PAR_TYP    = v.pt;
    tx_if.Prescale   = v.pre;
    tx_if.DATA_VALID = 1'b1;
    sb_q.push_back(v);
    @(posedge clk); #1;
    if (!hold) tx_if.DATA_VALID = 1'b0;
    check("accept_busy", tx_if.busy, 1);
    check("accept_start_bit", tx_if.TX_OUT, 0);
  endtask

  vec_t vecs[7];

  initial begin
    logic ok;
    int   n;

    vecs[0] = mk(8'hA5, 1'b0, 1'b0, 6'd1,  1'b0, 10);
    vecs[1] = mk(8'hA5, 1'b1, 1'b0, 6'd2,  1'b0, 22);
    vecs[2] = mk(8'hA5, 1'b1, 1'b1, 6'd2,  1'b1, 22);
    vecs[3] = mk(8'h3C, 1'b0, 1'b0, 6'd0,  1'b0, 10);
    vecs[4] = mk(8'h01, 1'b1, 1'b0, 6'd3,  1'b1, 33);
    vecs[5] = mk(8'h96, 1'b1, 1'b1, 6'd5,  1'b1, 55);
    vecs[6] = mk(8'hFF, 1'b1, 1'b1, 6'd63, 1'b1, 693);

    tx_if.P_DATA     = 8'h00;
    tx_if.PAR_EN     = 1'b0;
    tx_if.PAR_TYP    = 1'b0;
    tx_if.Prescale   = 6'd1;
    tx_if.DATA_VALID = 1'b0;

    // Asynchronous reset between edges takes effect at once.
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("reset_tx_out", tx_if.TX_OUT, 1);
    check("reset_busy", tx_if.busy, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    mon_en = 1'b1;

    ok = 1'b1;
    repeat (20) begin
      @(posedge clk); #1;
      if (tx_if.TX_OUT !== 1'b1 || tx_if.busy !== 1'b0) ok = 1'b0;
    end
    check("idle_hold_20", ok, 1);

    for (int i = 0; i < 7; i++) begin
      send(vecs[i], 1'b0);
      wait_done();
      repeat (2) @(posedge clk);
      #1;
    end

    // Inputs wiggling during a frame must not disturb it.
    send(mk(8'h80, 1'b1, 1'b0, 6'd16, 1'b1, 176), 1'b0);
    repeat (150) begin
      @(posedge clk); #1;
      tx_if.P_DATA     = 8'($urandom);
      tx_if.Prescale   = 6'($urandom);
      tx_if.PAR_EN     = 1'($urandom);
      tx_if.PAR_TYP    = 1'($urandom);
      tx_if.DATA_VALID = 1'($urandom);
    end
    tx_if.DATA_VALID = 1'b0;
    wait_done();

    // DATA_VALID held high: two frames with a single idle cycle between them.
    send(mk(8'h00, 1'b0, 1'b0, 6'd1, 1'b0, 10), 1'b1);
    tx_if.P_DATA = 8'hFF;
    sb_q.push_back(mk(8'hFF, 1'b0, 1'b0, 6'd1, 1'b0, 10));
    n = 0;
    while (tx_if.busy !== 1'b0 && n < 100) begin @(posedge clk); #1; n++; end
    while (tx_if.busy !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
    tx_if.DATA_VALID = 1'b0;
    if (n >= 100) check("b2b_timeout", n, 0);
    wait_done();
    check("b2b_idle_gap", last_gap, 1);

    // Reset during data bit 3 (a 0) of a P=8 frame.
    repeat (2) @(posedge clk);
    #1;
    send(mk(8'hC3, 1'b0, 1'b0, 6'd8, 1'b0, 80), 1'b0);
    repeat (34) @(posedge clk);
    #3;
    check("pre_abort_bit3", tx_if.TX_OUT, 0);
    rst = 1'b1;
    #1;
    check("abort_tx_out", tx_if.TX_OUT, 1);
    check("abort_busy", tx_if.busy, 0);
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    ok = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (tx_if.TX_OUT !== 1'b1 || tx_if.busy !== 1'b0) ok = 1'b0;
    end
    check("no_resume_after_reset", ok, 1);
    send(mk(8'hC3, 1'b1, 1'b0, 6'd8, 1'b0, 88), 1'b0);
    wait_done();

    check("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the system UART: accepts one 8-bit word per handshake and shifts it out on `TX_OUT` as one frame. A frame is a start bit, 8 data bits LSB-first, an optional parity bit and one stop bit. Each bit is held for a programmable number of `CLK` cycles. The block is the transmit-side counterpart of the UART receiver, sits beside it in the UART wrapper, and is fed from the system controller or a TX FIFO through a valid/busy handshake.

## Interface
- No parameters; frame format is fixed at 8 data bits and 1 stop bit.
- `CLK` input 1: single clock for the whole block.
- `RST` input 1: reset, asynchronous, active-high.
- `P_DATA` input 8: parallel word to transmit; sampled only on acceptance.
- `DATA_VALID` input 1: request to transmit `P_DATA`; sampled only when `busy`=0.
- `PAR_EN` input 1: 1 = insert parity bit; latched on acceptance.
- `PAR_TYP` input 1: 0 = even parity, 1 = odd parity; latched on acceptance.
- `Prescale` input 6: bit period in `CLK` cycles; latched on acceptance; 0 is treated as 1.
- `TX_OUT` output 1: serial line, registered, idles high.
- `busy` output 1: registered; high from acceptance until the end of the stop bit.

## Operation
- FSM states are IDLE, START, DATA, PARITY and STOP. State, bit counter, edge counter, shift register and latched config are all reset to zero or IDLE.
- IDLE:
  - `TX_OUT`=1 and `busy`=0.
  - On a rising edge with `DATA_VALID`=1, the block accepts: it latches `P_DATA`, `PAR_EN`, `PAR_TYP` and `Prescale` (P), then enters START.
- START: drives `TX_OUT`=0 for P cycles, then goes to DATA.
- DATA:
  - Drives bit k of the latched word (k = 0..7, LSB first), each for P cycles.
  - The 3-bit bit counter increments at the end of each bit.
  - After bit 7, goes to PARITY if the latched `PAR_EN`=1, otherwise to STOP.
- PARITY:
  - Drives the parity bit for P cycles, then goes to STOP.
  - Even parity: XOR of the 8 latched bits. Odd parity: the inverse of that XOR.
  - Parity is computed from the latched word, never from live `P_DATA`.
- STOP: drives `TX_OUT`=1 for P cycles, then returns to IDLE.
- Edge counter: 6 bits, counts 0..P-1 within each bit. The bit ends when the count equals P-1, at which point the counter wraps to 0.
- While `busy`=1:
  - `DATA_VALID` is ignored; the word is not queued and no error is flagged.
  - Changes on `P_DATA`, `PAR_EN`, `PAR_TYP` and `Prescale` have no effect on the frame in flight.
- Reset asserted mid-frame: aborts immediately and asynchronously; `TX_OUT`=1, `busy`=0, state IDLE. No partial frame resumes after reset is released.

## Timing
- Reset values: `TX_OUT`=1 and `busy`=0.
- Acceptance edge is cycle 0. At that edge `busy` rises and `TX_OUT` falls (start bit) together; there is no extra latency cycle.
- Frame length: N·P cycles, where N = 10 without parity and 11 with parity. `busy` is high for exactly N·P cycles.
- On the edge that ends the stop bit, `busy` falls and `TX_OUT` stays 1.
- Back-to-back transfers:
  - The earliest next acceptance is the first edge where `busy`=0 is seen by the requester, i.e. one IDLE cycle.
  - The minimum gap between stop-bit start and the next start bit is therefore P+1 cycles.
- `DATA_VALID` held high continuously sends frames back to back with that 1-cycle IDLE gap, re-sampling `P_DATA` each time.
- P=1: every bit lasts 1 cycle and the frame is 10 or 11 cycles; no state may be skipped.
- P=63 (maximum): the edge counter must not overflow. A latched P of 0 behaves exactly as P=1.

## Test plan
- Reset then idle: assert `RST` asynchronously between edges → `TX_OUT`=1 and `busy`=0 immediately. Hold 20 cycles with `DATA_VALID`=0 → no change.
- 0xA5, `PAR_EN`=0, P=1 → `TX_OUT` reads 0,1,0,1,0,0,1,0,1,1 on cycles 0..9. `busy` is high for exactly 10 cycles.
- 0xA5, `PAR_EN`=1, P=2:
  - `PAR_TYP`=0 → parity bit 0 on cycles 18–19.
  - `PAR_TYP`=1 → parity bit 1.
  - Frame lasts 22 cycles in both cases.
- 0x80, `PAR_EN`=1, `PAR_TYP`=0, P=16 → data bit 7 = 1 on cycles 128–143, parity 1 on cycles 144–159, stop on cycles 160–175, `busy` falls at cycle 176.
  - Toggling `P_DATA`, `Prescale` and `DATA_VALID` mid-frame leaves the waveform unchanged.
- `DATA_VALID` held high with words 0x00 then 0xFF, P=1, no parity → two frames separated by exactly one IDLE high cycle; second frame data bits are all 1.
- Reset pulse during data bit 3 of a P=8 frame → `TX_OUT`=1 and `busy`=0 at once. After release, the next accepted word produces a complete, correct frame.
